feature_result_arbiter: RTL and testbench
=========================================

Name: feature_result_arbiter

Overview:
- Collects the four per-channel feature results and shares one handshaked result bus between them: ZCR right, ZCR left, short-time energy, and mean-subtracted samples.
- Buffers each requester in a one-entry slot and grants the slots round-robin onto a registered valid/ready output.
- Tracks frame completion, meaning ZCR right, ZCR left and STE have all been delivered.
- Sits between the feature blocks and the host interface, all in the FIFO read clock domain.

Parameters:
- DATA_WIDTH, 16, width of the mean-subtracted sample and of out_data.
- ZCR_WIDTH, 6, width of the zero-crossing counts.

Ports:
- clk  input  1  FIFO read clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- zcr_r_count  input  ZCR_WIDTH  right-channel ZCR count.
- zcr_r_valid  input  1  single-cycle strobe qualifying zcr_r_count.
- zcr_l_count  input  ZCR_WIDTH  left-channel ZCR count.
- zcr_l_valid  input  1  single-cycle strobe qualifying zcr_l_count.
- ste_in  input  1  short-time-energy decision bit.
- ste_valid  input  1  strobe qualifying ste_in.
- sub_data  input  DATA_WIDTH  mean-subtracted sample.
- sub_valid  input  1  strobe qualifying sub_data.
- out_ready  input  1  downstream accepts the current result.
- overrun_clr  input  1  pulse; clears the overrun flags.
- out_valid  output  1  result present on out_tag/out_data.
- out_tag  output  2  source ID: 0 = ZCR right, 1 = ZCR left, 2 = STE, 3 = subMean.
- out_data  output  DATA_WIDTH  payload.
- frame_done  output  1  one-cycle pulse when a frame completes.
- frame_cnt  output  16  count of completed frames.
- overrun  output  4  sticky per-source drop flags, bit index = tag.

Behaviour:
- Reset, asynchronous while reset=0:
  - All slots empty.
  - out_valid=0, out_tag=0, out_data=0.
  - frame_done=0, frame_cnt=0, overrun=0.
  - Round-robin pointer=0; frame seen-flags cleared.
  - Reset mid-transfer discards all pending data; there is no recovery of held results.
- Slots: one register plus full flag per source.
  - A strobe sampled at edge k with the slot empty captures the data and sets full after edge k.
  - If the slot is full and is granted at that same edge, the new data is captured and full stays 1; no overrun.
  - If the slot is full and not granted, the new data is dropped, the old data is kept, and overrun[tag] is set.
- Payload formatting:
  - ZCR counts are zero-extended to DATA_WIDTH.
  - STE goes to bit 0, upper bits 0.
  - subMean is passed unchanged.
- Output register load condition: (out_valid==0) or (out_valid & out_ready).
  - When the condition holds and at least one slot is full, grant exactly one slot.
  - The granted slot's data loads into the output register, out_valid=1, and that slot's full clears (unless refilled the same edge).
  - When the condition holds and no slot is full, out_valid goes to 0.
  - While out_valid=1 and out_ready=0, out_tag/out_data are held stable.
- Throughput and latency:
  - Sustained throughput is one result per cycle with out_ready=1.
  - Minimum latency: strobe at edge k gives out_valid high after edge k+1.
- Arbitration: round-robin.
  - Search order starts at the pointer and wraps 3→0.
  - After a grant, pointer = granted tag + 1 (mod 4).
  - The pointer is unchanged when nothing is granted.
- Frame tracking:
  - seen_r, seen_l and seen_ste are set when tag 0, 1 or 2 is granted into the output register.
  - Completion occurs on the edge where all three become set, including when the last is set that edge. Then frame_done=1 for one cycle, all seen-flags clear, and frame_cnt increments, wrapping 0xFFFF→0.
  - A repeat grant of an already-seen tag before completion is allowed and does not alter the flags.
  - subMean grants never affect frame tracking.
- Overrun:
  - overrun_clr clears all bits.
  - If a set event and a clear coincide on the same bit, set wins.

Test Plan:
- Reset, single request: assert reset=0 mid-stream. Check all outputs are 0 immediately (asynchronous). Release reset, then with out_ready=1 pulse zcr_r_valid with count 6'd37 → out_valid=1, out_tag=0, out_data=16'd37 after the following edge.
- Fairness: pulse all four strobes in one cycle (ZCR right=5, ZCR left=9, STE=1, subMean=16'hFF80) with out_ready=1 → tags 0,1,2,3 emitted on consecutive cycles. frame_done pulses once, on the edge where tag 2 is loaded; frame_cnt=1.
- Backpressure hold: out_ready=0 for 10 cycles with subMean sample 16'h1234 in the output register → out_data holds 16'h1234 throughout. A second sub_valid (16'h5678) fills the slot; a third sub_valid sets overrun[3] and is dropped. After releasing out_ready, the output shows 16'h1234 then 16'h5678 only.
- Refill on grant: slot 3 full, output empty, and sub_valid arrives at the same edge the slot is granted → no overrun, and both samples are delivered in order.
- Frame counter wrap: preload via 65535 completed frames (or force frame_cnt=16'hFFFF) → the next completion gives frame_cnt=0 and frame_done=1.
- Overrun clear collision: overrun_clr pulses on the same cycle a new drop occurs on tag 1 → overrun[1]=1 and the other bits are 0.

Source files
------------

// File: rtl/feature_result_arbiter_if.sv
// Result bus between the feature arbiter and the host side.
// The arbiter drives the result and the host drives out_ready.
interface feature_result_arbiter_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            out_tag;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_tag,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_tag,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/feature_result_arbiter.sv
// Round-robin arbiter sharing one result bus between ZCR right/left,
// STE and subMean, with one-entry slots and frame completion tracking.
module feature_result_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ZCR_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ZCR_WIDTH-1:0]  zcr_r_count,
    input  logic                  zcr_r_valid,
    input  logic [ZCR_WIDTH-1:0]  zcr_l_count,
    input  logic                  zcr_l_valid,
    input  logic                  ste_in,
    input  logic                  ste_valid,
    input  logic [DATA_WIDTH-1:0] sub_data,
    input  logic                  sub_valid,
    input  logic                  overrun_clr,
    feature_result_arbiter_if.master rbus,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic [3:0]            overrun
);

    typedef logic [DATA_WIDTH-1:0] data_t;

    logic [3:0]  r_full;
    data_t       r_slot [4];
    logic [1:0]  r_ptr;
    logic        r_out_valid;
    logic [1:0]  r_out_tag;
    data_t       r_out_data;
    logic [2:0]  r_seen;
    logic        r_frame_done;
    logic [15:0] r_frame_cnt;
    logic [3:0]  r_overrun;

    logic [3:0]  w_stb;
    data_t       w_din [4];
    logic        w_gnt_any;
    logic [1:0]  w_gnt_idx;
    logic [1:0]  w_cand;
    logic        w_load;
    logic        w_take;
    logic [3:0]  w_gnt_vec;
    logic [3:0]  w_ovr_set;
    logic [2:0]  w_seen_nxt;
    logic        w_done;

    assign w_stb = {sub_valid, ste_valid, zcr_l_valid, zcr_r_valid};

    always_comb begin
        w_din[0] = DATA_WIDTH'(zcr_r_count);
        w_din[1] = DATA_WIDTH'(zcr_l_count);
        w_din[2] = DATA_WIDTH'(ste_in);
        w_din[3] = sub_data;
    end

    // Walk from the farthest candidate back to the pointer so the
    // nearest full slot in round-robin order wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = r_ptr;
        w_cand    = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            w_cand = r_ptr + 2'(i);
            if (r_full[w_cand]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    assign w_load    = !r_out_valid || rbus.out_ready;
    assign w_take    = w_load && w_gnt_any;
    assign w_gnt_vec = w_take ? (4'b0001 << w_gnt_idx) : 4'b0000;
    assign w_ovr_set = w_stb & r_full & ~w_gnt_vec;

    assign w_seen_nxt = r_seen | w_gnt_vec[2:0];
    assign w_done     = &w_seen_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= '0;
            for (int s = 0; s < 4; s++) r_slot[s] <= '0;
        end else begin
            for (int s = 0; s < 4; s++) begin
                if (w_stb[s] && (!r_full[s] || w_gnt_vec[s])) begin
                    r_slot[s] <= w_din[s];
                    r_full[s] <= 1'b1;
                end else if (w_gnt_vec[s]) begin
                    r_full[s] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            r_out_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_out_tag  <= w_gnt_idx;
                r_out_data <= r_slot[w_gnt_idx];
                r_ptr      <= w_gnt_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seen       <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_done <= w_done;
            if (w_done) begin
                r_seen      <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_seen <= w_seen_nxt;
            end
        end
    end

    // A drop in the same cycle as a clear keeps its bit set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= '0;
        end else begin
            r_overrun <= (overrun_clr ? 4'b0000 : r_overrun) | w_ovr_set;
        end
    end

    assign rbus.out_valid = r_out_valid;
    assign rbus.out_tag   = r_out_tag;
    assign rbus.out_data  = r_out_data;
    assign frame_done     = r_frame_done;
    assign frame_cnt      = r_frame_cnt;
    assign overrun        = r_overrun;

endmodule

// File: tb/tb_feature_result_arbiter.sv
// Directed bench for feature_result_arbiter with immediate assertions.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_feature_result_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  zcr_r_count, zcr_l_count;
    logic        zcr_r_valid, zcr_l_valid;
    logic        ste_in, ste_valid;
    logic [15:0] sub_data;
    logic        sub_valid;
    logic        overrun_clr;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic [3:0]  overrun;

    int n_tests = 0;
    int n_fail  = 0;

    feature_result_arbiter_if #(.DATA_WIDTH(16)) rbus ();

    feature_result_arbiter #(
        .DATA_WIDTH(16),
        .ZCR_WIDTH (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .zcr_r_count (zcr_r_count),
        .zcr_r_valid (zcr_r_valid),
        .zcr_l_count (zcr_l_count),
        .zcr_l_valid (zcr_l_valid),
        .ste_in      (ste_in),
        .ste_valid   (ste_valid),
        .sub_data    (sub_data),
        .sub_valid   (sub_valid),
        .overrun_clr (overrun_clr),
        .rbus        (rbus.master),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [1:0] t, input logic [15:0] d);
        chk({tag, ".valid"}, 32'(rbus.out_valid), 32'(v));
        chk({tag, ".tag"},   32'(rbus.out_tag),   32'(t));
        chk({tag, ".data"},  32'(rbus.out_data),  32'(d));
    endtask

    initial begin
        reset = 1'b0;
        zcr_r_count = '0; zcr_r_valid = 1'b0;
        zcr_l_count = '0; zcr_l_valid = 1'b0;
        ste_in = 1'b0; ste_valid = 1'b0;
        sub_data = '0; sub_valid = 1'b0;
        overrun_clr = 1'b0;
        rbus.out_ready = 1'b0;
        repeat (2) tick();
        chk_out("rst0", 1'b0, 2'd0, 16'h0);
        chk("rst0.fdone", 32'(frame_done), 32'd0);
        chk("rst0.fcnt", 32'(frame_cnt), 32'd0);
        chk("rst0.ovr", 32'(overrun), 32'd0);
        reset = 1'b1;
        tick();

        // Activity, then asynchronous reset in the middle of a cycle
        sub_data = 16'h00AA; sub_valid = 1'b1;
        tick();
        sub_valid = 1'b0;
        tick();
        chk_out("pre_rst", 1'b1, 2'd3, 16'h00AA);
        #2 reset = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 2'd0, 16'h0);
        chk("async_rst.fcnt", 32'(frame_cnt), 32'd0);
        chk("async_rst.ovr", 32'(overrun), 32'd0);
        reset = 1'b1;
        tick();

        // Single request latency
        rbus.out_ready = 1'b1;
        zcr_r_count = 6'd37; zcr_r_valid = 1'b1;
        tick();
        zcr_r_valid = 1'b0;
        chk("single.lat", 32'(rbus.out_valid), 32'd0);
        tick();
        chk_out("single", 1'b1, 2'd0, 16'd37);
        tick();
        chk("single.drain", 32'(rbus.out_valid), 32'd0);

        reset = 1'b0;
        #1 reset = 1'b1;
        tick();

        // Fairness: all four strobes together
        zcr_r_count = 6'd5; zcr_r_valid = 1'b1;
        zcr_l_count = 6'd9; zcr_l_valid = 1'b1;
        ste_in = 1'b1; ste_valid = 1'b1;
        sub_data = 16'hFF80; sub_valid = 1'b1;
        tick();
        zcr_r_valid = 1'b0; zcr_l_valid = 1'b0;
        ste_valid = 1'b0; sub_valid = 1'b0;
        tick();
        chk_out("fair0", 1'b1, 2'd0, 16'd5);
        chk("fair0.fdone", 32'(frame_done), 32'd0);
        tick();
        chk_out("fair1", 1'b1, 2'd1, 16'd9);
        chk("fair1.fdone", 32'(frame_done), 32'd0);
        tick();
        chk_out("fair2", 1'b1, 2'd2, 16'd1);
        chk("fair2.fdone", 32'(frame_done), 32'd1);
        chk("fair2.fcnt", 32'(frame_cnt), 32'd1);
        tick();
        chk_out("fair3", 1'b1, 2'd3, 16'hFF80);
        chk("fair3.fdone", 32'(frame_done), 32'd0);
        chk("fair3.fcnt", 32'(frame_cnt), 32'd1);
        tick();
        chk("fair.drain", 32'(rbus.out_valid), 32'd0);

        // Backpressure hold and overrun on slot 3
        sub_data = 16'h1234; sub_valid = 1'b1;
        tick();
        sub_valid = 1'b0;
        rbus.out_ready = 1'b0;
        tick();
        chk_out("bp.load", 1'b1, 2'd3, 16'h1234);
        sub_data = 16'h5678; sub_valid = 1'b1;
        tick();
        chk_out("bp.hold1", 1'b1, 2'd3, 16'h1234);
        chk("bp.ovr1", 32'(overrun), 32'd0);
        sub_data = 16'h9999;
        tick();
        sub_valid = 1'b0;
        chk_out("bp.hold2", 1'b1, 2'd3, 16'h1234);
        chk("bp.ovr2", 32'(overrun), 32'h8);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("bp.hold", 32'(rbus.out_data), 32'h1234);
        end
        rbus.out_ready = 1'b1;
        tick();
        chk_out("bp.next", 1'b1, 2'd3, 16'h5678);
        tick();
        chk("bp.drain", 32'(rbus.out_valid), 32'd0);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("bp.clr", 32'(overrun), 32'd0);

        // Refill on grant
        sub_data = 16'hAAAA; sub_valid = 1'b1;
        tick();
        sub_data = 16'hBBBB;
        tick();
        sub_valid = 1'b0;
        chk_out("refill.a", 1'b1, 2'd3, 16'hAAAA);
        chk("refill.ovr", 32'(overrun), 32'd0);
        tick();
        chk_out("refill.b", 1'b1, 2'd3, 16'hBBBB);
        tick();
        chk("refill.drain", 32'(rbus.out_valid), 32'd0);
        chk("refill.ovr2", 32'(overrun), 32'd0);

        // Frame counter wrap
        force dut.r_frame_cnt = 16'hFFFF;
        #1 release dut.r_frame_cnt;
        #1;
        chk("wrap.pre", 32'(frame_cnt), 32'hFFFF);
        tick();
        zcr_r_count = 6'd1; zcr_r_valid = 1'b1;
        zcr_l_count = 6'd2; zcr_l_valid = 1'b1;
        ste_in = 1'b0; ste_valid = 1'b1;
        tick();
        zcr_r_valid = 1'b0; zcr_l_valid = 1'b0; ste_valid = 1'b0;
        tick();
        chk_out("wrap0", 1'b1, 2'd0, 16'd1);
        tick();
        chk_out("wrap1", 1'b1, 2'd1, 16'd2);
        chk("wrap1.fdone", 32'(frame_done), 32'd0);
        tick();
        chk_out("wrap2", 1'b1, 2'd2, 16'd0);
        chk("wrap2.fdone", 32'(frame_done), 32'd1);
        chk("wrap2.fcnt", 32'(frame_cnt), 32'd0);
        tick();
        chk("wrap.fdone_off", 32'(frame_done), 32'd0);
        chk("wrap.fcnt_hold", 32'(frame_cnt), 32'd0);

        // Overrun clear colliding with a drop on tag 1
        rbus.out_ready = 1'b0;
        zcr_l_count = 6'd3; zcr_l_valid = 1'b1;
        tick();
        zcr_l_count = 6'd4;
        zcr_r_count = 6'd7; zcr_r_valid = 1'b1;
        tick();
        zcr_l_valid = 1'b0;
        chk_out("col.out", 1'b1, 2'd1, 16'd3);
        chk("col.ovr0", 32'(overrun), 32'd0);
        zcr_r_count = 6'd8;
        tick();
        zcr_r_valid = 1'b0;
        chk("col.ovr1", 32'(overrun), 32'h1);
        zcr_l_count = 6'd5; zcr_l_valid = 1'b1;
        overrun_clr = 1'b1;
        tick();
        zcr_l_valid = 1'b0;
        overrun_clr = 1'b0;
        chk("col.ovr2", 32'(overrun), 32'h2);
        rbus.out_ready = 1'b1;
        tick();
        chk_out("col.d0", 1'b1, 2'd0, 16'd7);
        tick();
        chk_out("col.d1", 1'b1, 2'd1, 16'd4);
        chk("col.fdone", 32'(frame_done), 32'd0);
        tick();
        chk("col.drain", 32'(rbus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
